membus_core_responder: RTL and testbench

- Slave end of the PDP-6 memory bus: a core memory module that answers read, write and read-modify-write cycles.
- Decodes the request against its module select, acknowledges the address, returns read data with rd_rs, and commits write data on wr_rs.
- Sits on the slave side of the bus connector and holds a synchronous 36-bit word array internally.

---
 rtl/membus_core_responder_pkg.sv | 17 +
 rtl/membus_core_responder_if.sv | 26 ++
 rtl/membus_core_responder_core_mem_array.sv | 19 +
 rtl/membus_core_responder.sv | 148 ++++++++++++++
 tb/tb_membus_core_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/membus_core_responder_pkg.sv
// Shared widths, state encoding and timer sizing for the PDP-6 core memory responder.
// Bus vectors are little-endian here: PDP-6 bit n of a word maps to vector bit 35-n.
package membus_pkg;
  localparam int WORD_W = 36;
  localparam int MA_W   = 15;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    READ,
    WAIT_WR,
    WRITE,
    DONE
  } state_e;
endpackage

// File: rtl/membus_core_responder_if.sv
// Memory bus connector between the processor side (master) and a core module (slave).
interface membus_core_responder_if;
  import membus_pkg::*;

  logic              wr_rs;
  logic              rq_cyc;
  logic              rd_rq;
  logic              wr_rq;
  logic [MA_W-1:0]   ma;
  logic [SEL_W-1:0]  sel;
  logic              fmc_select;
  logic [WORD_W-1:0] mb_write;
  logic              addr_ack;
  logic              rd_rs;
  logic [WORD_W-1:0] mb_read;

  modport master (
    output wr_rs, rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select, mb_write,
    input  addr_ack, rd_rs, mb_read
  );

  modport slave (
    input  wr_rs, rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select, mb_write,
    output addr_ack, rd_rs, mb_read
  );
endinterface

// File: rtl/membus_core_responder_core_mem_array.sv
// Single-port core word array: registered read, synchronous write, contents survive reset.
module core_mem_array #(
  parameter int AW = 15,
  parameter int DW = 36
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) rdata <= mem[addr];
  end
endmodule

// File: rtl/membus_core_responder.sv
// Core memory slave on the PDP-6 memory bus: read, write and read-modify-write cycles.
//
//   state   | meaning
//   IDLE    | waiting for a request addressed to this module
//   ACK     | timing out ACK_DLY, then pulse addr_ack
//   READ    | timing out RD_DLY, then pulse rd_rs with the word
//   WAIT_WR | waiting for wr_rs (or rq_cyc drop = abort)
//   WRITE   | timing out WR_DLY, then commit the latched word
//   DONE    | waiting for rq_cyc to drop before re-arming
module membus_core_responder
  import membus_pkg::*;
#(
  parameter logic [SEL_W-1:0] MEM_SEL = 4'b0000,
  parameter int AW      = 15,
  parameter int ACK_DLY = 2,
  parameter int RD_DLY  = 4,
  parameter int WR_DLY  = 4
) (
  input logic                     clk,
  input logic                     reset,
  membus_core_responder_if.slave  bus
);
  localparam logic [CNT_W-1:0] ACK_RLD = CNT_W'(ACK_DLY - 1);
  localparam logic [CNT_W-1:0] RD_RLD  = CNT_W'(RD_DLY - 1);
  localparam logic [CNT_W-1:0] WR_RLD  = CNT_W'(WR_DLY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     ma_q, ma_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              rs_q, rs_d;
  logic              mem_rd_en, mem_wr_en;
  logic [WORD_W-1:0] mem_rdata;
  logic              accept;
  logic              tc;

  assign accept = bus.rq_cyc & (bus.rd_rq | bus.wr_rq) & ~bus.fmc_select
                  & (bus.sel == MEM_SEL);
  assign tc     = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ma_d      = ma_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    ack_d     = 1'b0;
    rs_d      = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACK;
          cnt_d   = ACK_RLD;
          ma_d    = bus.ma[AW-1:0];
          rd_d    = bus.rd_rq;
          wr_d    = bus.wr_rq;
        end
      end
      ACK: begin
        if (tc) begin
          ack_d = 1'b1;
          if (rd_q) begin
            state_d = READ;
            cnt_d   = RD_RLD;
          end else begin
            state_d = WAIT_WR;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READ: begin
        // Array read issued in the last READ cycle so the word lands with rd_rs.
        mem_rd_en = tc;
        if (tc) begin
          rs_d    = 1'b1;
          state_d = wr_q ? WAIT_WR : DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_WR: begin
        if (bus.wr_rs) begin
          wdata_d = bus.mb_write;
          state_d = WRITE;
          cnt_d   = WR_RLD;
        end else if (!bus.rq_cyc) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        mem_wr_en = tc;
        if (tc) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (!bus.rq_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rs_q    <= rs_d;
    end
  end

  core_mem_array #(.AW(AW), .DW(WORD_W)) u_mem (
    .clk   (clk),
    .rd_en (mem_rd_en),
    .wr_en (mem_wr_en),
    .addr  (ma_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.addr_ack = ack_q;
  assign bus.rd_rs    = rs_q;
  assign bus.mb_read  = rs_q ? mem_rdata : '0;
endmodule

// File: tb/tb_membus_core_responder.sv
// Scoreboard bench for membus_core_responder: cycle-exact expected pulses queued at issue time.
module tb_membus_core_responder;
  import membus_pkg::*;

  localparam logic [3:0] MEM_SEL = 4'b0000;
  localparam int ACK_DLY = 2;
  localparam int RD_DLY  = 4;
  localparam int WR_DLY  = 4;
  localparam int RST_NONE = 0, RST_PRE_RD = 1, RST_IN_RD = 2, RST_IN_WR = 3;

  typedef struct {
    int          cyc;
    logic [35:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [35:0] model [int];
  int          ack_q [$];
  rd_exp_t     rd_q [$];
  logic [14:0] pool [6] = '{15'o00100, 15'o77777, 15'o00005, 15'o00000, 15'o12345, 15'o40000};

  membus_core_responder_if bus ();

  membus_core_responder #(
    .MEM_SEL (MEM_SEL),
    .AW      (15),
    .ACK_DLY (ACK_DLY),
    .RD_DLY  (RD_DLY),
    .WR_DLY  (WR_DLY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %o, expected %o", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the outputs must match exactly what the issued traffic predicts.
  always @(negedge clk) begin
    rd_exp_t e;
    if (ack_q.size() > 0 && ack_q[0] == cyc) begin
      void'(ack_q.pop_front());
      check("addr_ack", 36'(bus.addr_ack), 36'd1);
    end else begin
      check("addr_ack_quiet", 36'(bus.addr_ack), 36'd0);
    end
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      e = rd_q.pop_front();
      check("rd_rs", 36'(bus.rd_rs), 36'd1);
      check("mb_read", bus.mb_read, e.data);
    end else begin
      check("rd_rs_quiet", 36'(bus.rd_rs), 36'd0);
      check("mb_read_zero", bus.mb_read, 36'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.rq_cyc     = 1'b0;
    bus.rd_rq      = 1'b0;
    bus.wr_rq      = 1'b0;
    bus.wr_rs      = 1'b0;
    bus.fmc_select = 1'b0;
    bus.sel        = MEM_SEL;
    bus.ma         = '0;
    bus.mb_write   = '0;
  endtask

  task automatic wait_out(input bit want_rd, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.wr_rs = 1'b0;
      if (want_rd ? bus.rd_rs : bus.addr_ack) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: no pulse within 40 cycles, required one", name);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_addr_ack", 36'(bus.addr_ack), 36'd0);
    check("rst_rd_rs", 36'(bus.rd_rs), 36'd0);
    check("rst_mb_read", bus.mb_read, 36'd0);
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_txn(input bit rd, input bit wr, input logic [14:0] a,
                         input logic [35:0] wd, input bit abort, input int hold,
                         input int rst_mode);
    int          acc;
    logic [35:0] old;
    old = model.exists(int'(a)) ? model[int'(a)] : 36'd0;
    @(negedge clk);
    bus.rq_cyc = 1'b1;
    bus.rd_rq  = rd;
    bus.wr_rq  = wr;
    bus.ma     = a;
    bus.sel    = MEM_SEL;
    bus.fmc_select = 1'b0;
    acc = cyc + 1;
    ack_q.push_back(acc + ACK_DLY);
    if (rd && rst_mode != RST_PRE_RD) rd_q.push_back('{acc + ACK_DLY + RD_DLY, old});
    @(negedge clk);
    // After accept, request qualifiers and address are don't-care; an early wr_rs is ignored.
    bus.rd_rq      = 1'($urandom);
    bus.wr_rq      = 1'($urandom);
    bus.fmc_select = 1'($urandom);
    bus.sel        = 4'($urandom);
    bus.ma         = 15'($urandom);
    if (wr && $urandom_range(0, 1) == 1) begin
      bus.wr_rs    = 1'b1;
      bus.mb_write = {$urandom, 4'($urandom)};
    end
    wait_out(1'b0, "addr_ack");
    if (rst_mode == RST_PRE_RD) begin
      while (cyc < acc + ACK_DLY + RD_DLY - 1) @(negedge clk);
      pulse_reset();
      return;
    end
    if (rd) wait_out(1'b1, "rd_rs");
    if (rst_mode == RST_IN_RD) begin
      pulse_reset();
      return;
    end
    if (wr) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (abort) begin
        bus.rq_cyc = 1'b0;
      end else begin
        bus.wr_rs    = 1'b1;
        bus.mb_write = wd;
        @(negedge clk);
        bus.wr_rs    = 1'b0;
        bus.mb_write = {$urandom, 4'($urandom)};
        if (rst_mode == RST_IN_WR) begin
          @(negedge clk);
          pulse_reset();
          return;
        end
        model[int'(a)] = wd;
      end
    end
    repeat (hold) @(negedge clk);
    idle_inputs();
    repeat (WR_DLY + 3) @(negedge clk);
  endtask

  task automatic reject(input int kind);
    @(negedge clk);
    bus.rq_cyc = 1'b1;
    bus.rd_rq  = 1'b1;
    bus.wr_rq  = 1'b1;
    bus.ma     = 15'o00100;
    case (kind)
      0:       bus.fmc_select = 1'b1;
      1:       bus.sel = MEM_SEL ^ 4'($urandom_range(1, 15));
      default: begin bus.rd_rq = 1'b0; bus.wr_rq = 1'b0; end
    endcase
    repeat (20) @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    logic [14:0] a;
    logic [35:0] wd;
    int          kind;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_addr_ack", 36'(bus.addr_ack), 36'd0);
    check("reset_rd_rs", 36'(bus.rd_rs), 36'd0);
    check("reset_mb_read", bus.mb_read, 36'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    bus_txn(0, 1, 15'o00100, 36'o123456701234, 0, 0, RST_NONE);
    bus_txn(1, 0, 15'o00100, '0, 0, 0, RST_NONE);
    bus_txn(0, 1, 15'o77777, 36'o777777000000, 0, 0, RST_NONE);
    bus_txn(1, 0, 15'o77777, '0, 0, 0, RST_NONE);
    bus_txn(0, 1, 15'o00005, 36'o1, 0, 0, RST_NONE);
    bus_txn(1, 1, 15'o00005, 36'o2, 0, 0, RST_NONE);
    bus_txn(1, 0, 15'o00005, '0, 0, 0, RST_NONE);

    for (int k = 0; k < 3; k++) reject(k);
    bus_txn(1, 0, 15'o00100, '0, 0, 0, RST_NONE);

    bus_txn(0, 1, 15'o00005, 36'o7777, 1, 0, RST_NONE);
    bus_txn(1, 0, 15'o00005, '0, 0, 0, RST_NONE);
    bus_txn(1, 0, 15'o00100, '0, 0, 12, RST_NONE);

    bus_txn(1, 0, 15'o77777, '0, 0, 0, RST_PRE_RD);
    bus_txn(1, 0, 15'o77777, '0, 0, 0, RST_NONE);
    bus_txn(1, 1, 15'o00005, 36'o3, 0, 0, RST_IN_RD);
    bus_txn(1, 0, 15'o00005, '0, 0, 0, RST_NONE);
    bus_txn(0, 1, 15'o00100, 36'o55, 0, 0, RST_IN_WR);
    bus_txn(1, 0, 15'o00100, '0, 0, 0, RST_NONE);

    for (int n = 0; n < 40; n++) begin
      a    = pool[$urandom_range(0, 5)];
      kind = model.exists(int'(a)) ? int'($urandom_range(0, 3)) : 1;
      wd   = {$urandom, 4'($urandom)};
      bus_txn(kind == 0 || kind == 2, kind != 0, a, wd, kind == 3,
              int'($urandom_range(0, 3)), RST_NONE);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
